// File: rtl/apb_spi_fifo_regif.sv
// APB register interface for the SPI master: control/status registers, TX/RX FIFOs,
// run/wait/stop mode sequencing and the registered interrupt request.
module apb_spi_fifo_regif #(
  parameter int DW       = 8,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic [2:0]    PADDR,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [DW-1:0] PWDATA,
  output logic [DW-1:0] PRDATA,
  output logic          PREADY,
  output logic          PSLVERR,
  input  logic          ss,
  input  logic          tip,
  input  logic [DW-1:0] miso_data,
  input  logic          receive_data,
  input  logic          send_ack,
  output logic [DW-1:0] mosi_data,
  output logic          send_data,
  output logic          mstr,
  output logic          cpol,
  output logic          cpha,
  output logic          lsbfe,
  output logic          spiswai,
  output logic [2:0]    sppr,
  output logic [2:0]    spr,
  output logic [1:0]    spi_mode,
  output logic          spi_interrupt_request
);

  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int TXCW = TXAW + 1;
  localparam int RXAW = $clog2(RX_DEPTH);
  localparam int RXCW = RXAW + 1;
  localparam logic [TXCW-1:0] TX_FULL_CNT = TXCW'(TX_DEPTH);
  localparam logic [RXCW-1:0] RX_FULL_CNT = RXCW'(RX_DEPTH);

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_WAIT = 2'b01,
    MODE_STOP = 2'b10
  } mode_e;

  logic [7:0]      r_cr1, r_cr2, r_br;
  logic            r_ovr, r_irq;
  mode_e           r_mode, w_modeNext;

  logic [DW-1:0]   r_txMem [TX_DEPTH];
  logic [TXAW-1:0] r_txRd, r_txWr;
  logic [TXCW-1:0] r_txCount;
  logic [DW-1:0]   r_rxMem [RX_DEPTH];
  logic [RXAW-1:0] r_rxRd, r_rxWr;
  logic [RXCW-1:0] r_rxCount;

  logic w_access, w_err, w_commit;
  logic w_cr1We, w_cr2We, w_brWe, w_srRd, w_flush;
  logic w_txPush, w_txPop, w_txEmpty, w_txFull;
  logic w_rxPush, w_rxPop, w_rxEmpty, w_rxFull, w_rxReq, w_ovrSet;
  logic w_spe, w_spie, w_sptie, w_ssoe, w_modfen, w_modf;
  logic [7:0]    w_sr, w_lvl, w_ctrlRd;
  logic [DW-1:0] w_rdData;

  assign w_spe    = r_cr1[6];
  assign w_spie   = r_cr1[7];
  assign w_sptie  = r_cr1[5];
  assign w_ssoe   = r_cr1[1];
  assign w_modfen = r_cr2[4];

  assign w_txEmpty = (r_txCount == '0);
  assign w_txFull  = (r_txCount == TX_FULL_CNT);
  assign w_rxEmpty = (r_rxCount == '0);
  assign w_rxFull  = (r_rxCount == RX_FULL_CNT);
  assign w_modf    = mstr & w_modfen & ~w_ssoe & ~ss;

  assign w_access = PSEL & PENABLE;
  assign PREADY   = w_access;

  always_comb begin
    w_err = 1'b0;
    case (PADDR)
      3'd0, 3'd1, 3'd2: w_err = PWRITE & tip;
      3'd3, 3'd4:       w_err = PWRITE;
      3'd5:             w_err = PWRITE ? w_txFull : w_rxEmpty;
      default:          w_err = 1'b1;
    endcase
  end

  assign PSLVERR  = w_access & w_err;
  assign w_commit = w_access & ~w_err;
  assign w_cr1We  = w_commit & PWRITE & (PADDR == 3'd0);
  assign w_cr2We  = w_commit & PWRITE & (PADDR == 3'd1);
  assign w_brWe   = w_commit & PWRITE & (PADDR == 3'd2);
  assign w_srRd   = w_commit & ~PWRITE & (PADDR == 3'd3);
  assign w_txPush = w_commit & PWRITE & (PADDR == 3'd5);
  assign w_rxPop  = w_commit & ~PWRITE & (PADDR == 3'd5);
  // Only a 1->0 transition of spe flushes; rewriting spe=0 leaves queued data alone.
  assign w_flush  = w_cr1We & w_spe & ~PWDATA[6];

  assign w_txPop  = send_ack & ~w_txEmpty;
  assign w_rxReq  = receive_data & (r_mode != MODE_STOP);
  // When full, an incoming word can only land if the APB side frees the head slot this cycle.
  assign w_rxPush = w_rxReq & (~w_rxFull | w_rxPop);
  assign w_ovrSet = w_rxReq & w_rxFull & ~w_rxPop;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_cr1 <= 8'h04;
      r_cr2 <= 8'h00;
      r_br  <= 8'h00;
    end else begin
      if (w_cr1We) r_cr1 <= PWDATA[7:0];
      if (w_cr2We) r_cr2 <= PWDATA[7:0] & 8'h1B;
      if (w_brWe)  r_br  <= PWDATA[7:0] & 8'h77;
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_txPush && !PRESET && !w_flush) r_txMem[r_txWr] <= PWDATA;
    if (w_rxPush && !PRESET && !w_flush) r_rxMem[r_rxWr] <= miso_data;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET || w_flush) begin
      r_txRd    <= '0;
      r_txWr    <= '0;
      r_txCount <= '0;
    end else begin
      if (w_txPush) r_txWr <= r_txWr + 1'b1;
      if (w_txPop)  r_txRd <= r_txRd + 1'b1;
      case ({w_txPush, w_txPop})
        2'b10:   r_txCount <= r_txCount + 1'b1;
        2'b01:   r_txCount <= r_txCount - 1'b1;
        default: r_txCount <= r_txCount;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET || w_flush) begin
      r_rxRd    <= '0;
      r_rxWr    <= '0;
      r_rxCount <= '0;
    end else begin
      if (w_rxPush) r_rxWr <= r_rxWr + 1'b1;
      if (w_rxPop)  r_rxRd <= r_rxRd + 1'b1;
      case ({w_rxPush, w_rxPop})
        2'b10:   r_rxCount <= r_rxCount + 1'b1;
        2'b01:   r_rxCount <= r_rxCount - 1'b1;
        default: r_rxCount <= r_rxCount;
      endcase
    end
  end

  // A fresh overrun outranks the clear-on-SR-read in the same cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_ovr <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ovrSet)    r_ovr <= 1'b1;
      else if (w_srRd) r_ovr <= 1'b0;
      r_irq <= (w_spie & (~w_rxEmpty | w_modf | r_ovr)) | (w_sptie & w_txEmpty);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) r_mode <= MODE_RUN;
    else        r_mode <= w_modeNext;
  end

  always_comb begin
    w_modeNext = r_mode;
    case (r_mode)
      MODE_RUN:  if (!w_spe) w_modeNext = MODE_WAIT;
      MODE_WAIT: begin
        if (w_spe)        w_modeNext = MODE_RUN;
        else if (spiswai) w_modeNext = MODE_STOP;
      end
      MODE_STOP: begin
        if (w_spe)         w_modeNext = MODE_RUN;
        else if (!spiswai) w_modeNext = MODE_WAIT;
      end
      default:   w_modeNext = MODE_RUN;
    endcase
  end

  assign w_sr  = {~w_rxEmpty, r_ovr, w_txEmpty, w_modf, w_txFull, w_rxFull, 2'b00};
  assign w_lvl = {4'(r_rxCount), 4'(r_txCount)};

  always_comb begin
    w_ctrlRd = 8'h00;
    w_rdData = '0;
    case (PADDR)
      3'd0: w_ctrlRd = r_cr1;
      3'd1: w_ctrlRd = r_cr2;
      3'd2: w_ctrlRd = r_br;
      3'd3: w_ctrlRd = w_sr;
      3'd4: w_ctrlRd = w_lvl;
      default: w_ctrlRd = 8'h00;
    endcase
    if (PADDR == 3'd5) w_rdData = w_rxEmpty ? '0 : r_rxMem[r_rxRd];
    else               w_rdData = DW'(w_ctrlRd);
  end

  assign PRDATA = (w_access & ~PWRITE) ? w_rdData : '0;

  assign mosi_data = w_txEmpty ? '0 : r_txMem[r_txRd];
  assign send_data = ~w_txEmpty & w_spe & (r_mode != MODE_STOP);

  assign mstr    = r_cr1[4];
  assign cpol    = r_cr1[3];
  assign cpha    = r_cr1[2];
  assign lsbfe   = r_cr1[0];
  assign spiswai = r_cr2[1];
  assign sppr    = r_br[6:4];
  assign spr     = r_br[2:0];
  assign spi_mode = r_mode;
  assign spi_interrupt_request = r_irq;

endmodule

// File: doc/apb_spi_fifo_regif.md
Name: apb_spi_fifo_regif

Overview:
- Next-generation APB slave register interface for the SPI master core.
- Replaces the single-byte data register with parametrised TX and RX FIFOs and a parametrised data width.
- Adds a FIFO level register, sticky RX overrun, a configuration lock while a transfer is in progress, and PSLVERR on illegal accesses.
- Sits between the APB bus and the SPI shift/baud logic; drives the configuration fields, the TX head word and send_data, and absorbs received words.

Parameters:
- DW, 8, APB data and SPI frame width; legal values 8, 16, 32. Control registers use bits [7:0]; upper bits read 0.
- TX_DEPTH, 4, TX FIFO depth in words; power of 2, 2..8.
- RX_DEPTH, 4, RX FIFO depth in words; power of 2, 2..8.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PADDR  in  3  register address.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PWDATA  in  DW  write data.
- PRDATA  out  DW  read data.
- PREADY  out  1  transfer ready.
- PSLVERR  out  1  transfer error.
- ss  in  1  slave-select feedback.
- tip  in  1  transfer in progress.
- miso_data  in  DW  received word.
- receive_data  in  1  one-cycle strobe: miso_data valid.
- send_ack  in  1  one-cycle strobe: core consumed the TX head.
- mosi_data  out  DW  TX FIFO head word.
- send_data  out  1  TX word available to the core.
- mstr, cpol, cpha, lsbfe, spiswai  out  1 each  configuration fields.
- sppr, spr  out  3 each  baud-rate selects.
- spi_mode  out  2  run=00, wait=01, stop=10.
- spi_interrupt_request  out  1  interrupt.

Behaviour:
- Register map:
  - 0 CR1: R/W, reset 0x04. [7]spie [6]spe [5]sptie [4]mstr [3]cpol [2]cpha [1]ssoe [0]lsbfe.
  - 1 CR2: R/W, write mask 0x1B, reset 0x00. [4]modfen [1]spiswai.
  - 2 BR: R/W, write mask 0x77, reset 0x00. sppr=[6:4], spr=[2:0].
  - 3 SR: read-only. [7]spif=RX not empty, [6]ovr (sticky), [5]sptef=TX empty, [4]modf, [3]txfull, [2]rxfull, [1:0]=0.
  - 4 LVL: read-only. [7:4]=rx_count, [3:0]=tx_count.
  - 5 DR: write pushes TX FIFO; read pops RX FIFO.
  - 6, 7: reserved.
- APB timing:
  - Zero wait states: PREADY = PSEL & PENABLE.
  - An access commits on the PCLK edge where PSEL & PENABLE are high.
  - PRDATA is the selected value during a read access, 0 otherwise; it is combinational from current state.
- PSLVERR is asserted in the access cycle only, and the access then has no side effect, for:
  - address 6 or 7;
  - a write to SR or LVL;
  - a DR write with the TX FIFO full;
  - a DR read with the RX FIFO empty (PRDATA=0);
  - a CR1, CR2 or BR write while tip=1.
- modf = mstr & modfen & ~ssoe & ~ss.
- TX FIFO:
  - send_data = TX not empty & spe & spi_mode≠stop.
  - mosi_data = head word; it is 0 when the FIFO is empty.
  - send_ack pops only if the FIFO is non-empty; otherwise it is ignored.
  - Full is judged on the pre-edge count, so a push at full is rejected even with a simultaneous send_ack.
  - Simultaneous push and pop when not full: count unchanged.
- RX FIFO:
  - receive_data pushes miso_data when spi_mode≠stop; in stop mode the strobe is ignored.
  - Push when full without a simultaneous APB pop: word dropped, ovr set.
  - Push when full with a simultaneous APB pop: both succeed and ovr is not set.
  - ovr clears on the commit of an SR read; a new overrun in the same cycle wins (ovr stays 1).
- Pointers wrap modulo depth. Counts have width clog2(depth)+1.
- Mode FSM, reset to run:
  - run→wait when !spe.
  - wait→run when spe; else wait→stop when spiswai.
  - stop→run when spe; else stop→wait when !spiswai.
  - FIFOs are held, not flushed, in wait and stop.
- Clearing spe (CR1 write) flushes both FIFOs on the same edge; ovr is unaffected.
- Interrupt, registered (one-cycle latency from its sources):
  - irq <= (spie & (spif|modf|ovr)) | (sptie & sptef).
- Reset, with PRESET=1 at an edge (mid-transfer included) and taking priority over all accesses and strobes:
  - FIFOs empty; ovr=0; irq=0; spi_mode=00; CR1=0x04, CR2=0, BR=0.
  - Consequent outputs: send_data=0, mosi_data=0, cpha=1, other config outputs 0.

Test Plan:
- Reset → CR1 reads 0x04, SR reads 0x20, LVL 0x00, spi_interrupt_request=0, send_data=0. Re-assert PRESET mid-stream → same values next cycle.
- With spe=1, push DR 0xA1,0xA2,0xA3,0xA4 (DW=8, TX_DEPTH=4); 5th push 0xA5 → PSLVERR=1, LVL=0x04, txfull=1. Pulse send_ack ×4 → mosi_data sequence A1..A4, then send_data=0 and sptef=1.
- Five receive_data strobes (0x11..0x15) with no APB reads → LVL=0x40, ovr=1; DR reads return 0x11..0x14; a 5th read → PSLVERR, PRDATA=0. SR read clears ovr.
- RX full plus receive_data in the same cycle as a DR read → both succeed, ovr stays 0, rx_count stays 4.
- tip=1 and write CR1=0x50 → PSLVERR=1, CR1 unchanged. Accesses to address 7 or writes to address 3 → PSLVERR=1.
- spie=1, sptie=0: first receive_data → irq=1 one cycle after spif rises. Clear spe with spiswai=1 → mode 00→01→10 on successive edges. receive_data in stop mode → rx_count unchanged.
